// File: rtl/gradient_update_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gradient_pkg
//  Description : Shared constants, state encoding and helpers for the
//                gradient update sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package gradient_pkg;

    // Default Q-format of the parameter store.
    localparam int Q_FIXED_BITS = 8;
    localparam int Q_FRAC_BITS  = 8;
    localparam int Q_NUM_WEIGHTS = 16;

    localparam int Q_W = Q_FIXED_BITS + Q_FRAC_BITS;
    localparam logic [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};
    localparam int ROUND_HALF = 1 << (Q_FRAC_BITS - 1);

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_CALC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        CALC  = ST_CALC,
        WRITE = ST_WRITE,
        DONE  = ST_DONE
    } state_t;

    // Index width; a single-entry store still gets a 1-bit address.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gradient_update_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : gradient_update_sched_if
//  Description : Control and storage bus of the gradient update sequencer.
//                slave = sequencer side, master = control/storage side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gradient_update_sched_if #(
    parameter int W      = 16,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              abort;
    logic [W-1:0]      lr;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      rd_grad;
    logic [W-1:0]      rd_weight;
    logic              wr_en;
    logic [W-1:0]      wr_weight;
    logic              grad_clr;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, lr, rd_grad, rd_weight,
        input  rd_en, addr, wr_en, wr_weight, grad_clr, busy, done
    );

    modport slave (
        input  start, abort, lr, rd_grad, rd_weight,
        output rd_en, addr, wr_en, wr_weight, grad_clr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/gradient_update_sched_alu.sv
`default_nettype none
// ============================================================================
//  Module      : sgd_update_alu
//  Description : Combinational SGD step w_new = sat(w - round(lr*g)) in
//                signed Q-format.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgd_update_alu #(
    parameter int W = 16,
    parameter int F = 8
) (
    input  wire logic [W-1:0] i_lr,
    input  wire logic [W-1:0] i_grad,
    input  wire logic [W-1:0] i_weight,
    output logic      [W-1:0] o_weight
);
    // One extra bit over the full product so the rounding add never wraps.
    localparam logic [2*W:0] c_round = {{(2*W){1'b0}}, 1'b1} << (F - 1);

    logic [2*W:0]        w_lr_x;
    logic [2*W:0]        w_grad_x;
    logic [2*W:0]        w_prod;
    logic [2*W:0]        w_rounded;
    logic signed [2*W:0] w_shifted;
    logic                w_delta_fits;
    logic [W:0]          w_delta;
    logic [W+1:0]        w_diff;
    logic                w_diff_fits;

    // Multiply, round half up, clamp delta to W+1 bits, subtract, clamp to W.
    always_comb begin
        w_lr_x    = {{(W+1){i_lr[W-1]}}, i_lr};
        w_grad_x  = {{(W+1){i_grad[W-1]}}, i_grad};
        w_prod    = w_lr_x * w_grad_x;
        w_rounded = w_prod + c_round;
        w_shifted = $signed(w_rounded) >>> F;

        w_delta_fits = (&w_shifted[2*W:W]) | ~(|w_shifted[2*W:W]);
        if (w_delta_fits)
            w_delta = w_shifted[W:0];
        else if (w_shifted[2*W])
            w_delta = {1'b1, {W{1'b0}}};
        else
            w_delta = {1'b0, {W{1'b1}}};

        w_diff = {{2{i_weight[W-1]}}, i_weight} - {w_delta[W], w_delta};

        w_diff_fits = (&w_diff[W+1:W-1]) | ~(|w_diff[W+1:W-1]);
        if (w_diff_fits)
            o_weight = w_diff[W-1:0];
        else if (w_diff[W+1])
            o_weight = {1'b1, {(W-1){1'b0}}};
        else
            o_weight = {1'b0, {(W-1){1'b1}}};
    end

endmodule
`default_nettype wire

// File: rtl/gradient_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : gradient_update_sched
//  Description : Walks the parameter store once per start, applying one SGD
//                step per entry (READ -> CALC -> WRITE) and clearing each
//                gradient as its weight is written back.
//  Revision    : 1.0 - initial release
// ============================================================================
module gradient_update_sched
    import gradient_pkg::*;
#(
    parameter int FIXED_BITS      = Q_FIXED_BITS,
    parameter int FRACTIONAL_BITS = Q_FRAC_BITS,
    parameter int NUM_WEIGHTS     = Q_NUM_WEIGHTS,
    parameter int ADDR_W          = addr_width(NUM_WEIGHTS)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    gradient_update_sched_if.slave bus
);
    localparam int W = FIXED_BITS + FRACTIONAL_BITS;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_WEIGHTS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [W-1:0]      lr_q, lr_d;
    logic [W-1:0]      wr_weight_q, wr_weight_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W-1:0]      w_alu_weight;

    sgd_update_alu #(
        .W (W),
        .F (FRACTIONAL_BITS)
    ) u_alu (
        .i_lr     (lr_q),
        .i_grad   (bus.rd_grad),
        .i_weight (bus.rd_weight),
        .o_weight (w_alu_weight)
    );

    // Next-state, index and latched operands; strobes decode the next state
    // so that every output leaves a flop.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lr_d        = lr_q;
        wr_weight_d = wr_weight_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    lr_d    = bus.lr;
                    addr_d  = '0;
                    state_d = READ;
                end
            end
            READ:  state_d = CALC;
            CALC: begin
                wr_weight_d = w_alu_weight;
                state_d     = WRITE;
            end
            WRITE: begin
                if (addr_q == c_last_addr) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = READ;
                end
            end
            DONE: begin
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                addr_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Abort overrides the walk; the current cycle's strobes are already
        // registered so they still complete.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            addr_d  = '0;
        end

        rd_en_d = (state_d == READ);
        wr_en_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // Sequencer state, index, operands and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            lr_q        <= '0;
            wr_weight_q <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lr_q        <= lr_d;
            wr_weight_q <= wr_weight_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.addr      = addr_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_weight = wr_weight_q;
    assign bus.grad_clr  = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gradient_update_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gradient_update_sched
//  Description : Directed and randomized passes of the gradient update
//                sequencer against a behavioural store and SGD model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gradient_update_sched;
    localparam int FB    = 8;
    localparam int FR    = 8;
    localparam int N     = 4;
    localparam int W     = FB + FR;
    localparam int AW    = 2;
    localparam int MAXC  = 3 * N + 6;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gradient_update_sched_if #(.W(W), .ADDR_W(AW)) bus ();

    gradient_update_sched #(
        .FIXED_BITS      (FB),
        .FRACTIONAL_BITS (FR),
        .NUM_WEIGHTS     (N),
        .ADDR_W          (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural parameter store and its contents before the current pass.
    logic [W-1:0] gmem [N];
    logic [W-1:0] wmem [N];
    logic [W-1:0] g0   [N];
    logic [W-1:0] w0   [N];

    // Outputs observed in each cycle of the current pass (cycle 0 = start).
    logic         s_rd    [MAXC+1];
    logic         s_wr    [MAXC+1];
    logic         s_clr   [MAXC+1];
    logic         s_busy  [MAXC+1];
    logic         s_done  [MAXC+1];
    int           s_addr  [MAXC+1];
    logic [W-1:0] s_wdata [MAXC+1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // w - round_half_up(lr*g / 2^FR), with the delta and result clamped.
    function automatic logic [W-1:0] sgd_ref(input logic [W-1:0] lr, input logic [W-1:0] g,
                                             input logic [W-1:0] w);
        longint p, d, r;
        p = longint'($signed(lr)) * longint'($signed(g)) + (longint'(1) << (FR - 1));
        if (p >= 0) d = p / (longint'(1) << FR);
        else        d = -((-p + (longint'(1) << FR) - 1) / (longint'(1) << FR));
        if (d > (longint'(1) << W) - 1) d = (longint'(1) << W) - 1;
        if (d < -(longint'(1) << W))    d = -(longint'(1) << W);
        r = longint'($signed(w)) - d;
        if (r > (longint'(1) << (W - 1)) - 1) r = (longint'(1) << (W - 1)) - 1;
        if (r < -(longint'(1) << (W - 1)))    r = -(longint'(1) << (W - 1));
        return r[W-1:0];
    endfunction

    // Runs one pass from a negedge in IDLE; also plays the storage side.
    task automatic run_pass(input logic [W-1:0] lr_v, input int abort_at, input int rst_at,
                            input int restart_at, input logic [W-1:0] lr2);
        for (int i = 0; i < N; i++) begin
            g0[i] = gmem[i];
            w0[i] = wmem[i];
        end
        s_rd[0]       = 1'b0;
        bus.start     = 1'b1;
        bus.lr        = lr_v;
        bus.abort     = 1'b0;
        bus.rd_grad   = W'($urandom);
        bus.rd_weight = W'($urandom);
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clk);
            @(negedge clk);
            s_rd[c]    = bus.rd_en;
            s_wr[c]    = bus.wr_en;
            s_clr[c]   = bus.grad_clr;
            s_busy[c]  = bus.busy;
            s_done[c]  = bus.done;
            s_addr[c]  = int'(bus.addr);
            s_wdata[c] = bus.wr_weight;
            if (s_wr[c])  wmem[s_addr[c]] = s_wdata[c];
            if (s_clr[c]) gmem[s_addr[c]] = '0;
            if (s_rd[c-1]) begin
                bus.rd_grad   = gmem[s_addr[c-1]];
                bus.rd_weight = wmem[s_addr[c-1]];
            end else begin
                bus.rd_grad   = W'($urandom);
                bus.rd_weight = W'($urandom);
            end
            bus.start = (c == restart_at);
            bus.lr    = (c == restart_at) ? lr2 : W'($urandom);
            bus.abort = (c == abort_at);
            rst       = (c == rst_at);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b0;
    endtask

    // Compares the observed pass with the entry-by-entry model; stop_at is
    // the cycle in which abort/reset hit (NEVER for a complete pass).
    task automatic check_pass(input string tag, input logic [W-1:0] lr_v, input int stop_at,
                              input bit exp_done);
        int           nwr, nrd, k, clr_bad, busy_bad, done_n, done_c, rd_n, bend;
        logic [W-1:0] e_data [N];
        nwr = 0;
        nrd = 0;
        for (int i = 0; i < N; i++) begin
            e_data[i] = sgd_ref(lr_v, g0[i], w0[i]);
            if (3 + 3 * i <= stop_at) nwr++;
            if (1 + 3 * i <= stop_at) nrd++;
        end
        bend     = exp_done ? 3 * N + 1 : stop_at;
        k        = 0;
        clr_bad  = 0;
        busy_bad = 0;
        done_n   = 0;
        done_c   = -1;
        rd_n     = 0;
        for (int c = 1; c <= MAXC; c++) begin
            if (s_wr[c]) begin
                if (k < N) begin
                    check({tag, "/wr_addr"}, s_addr[c], k);
                    check({tag, "/wr_data"}, 32'(s_wdata[c]), 32'(e_data[k]));
                end
                k++;
            end
            if (s_clr[c] !== s_wr[c]) clr_bad++;
            if (s_busy[c] !== (c <= bend)) busy_bad++;
            if (s_done[c]) begin
                done_n++;
                done_c = c;
            end
            if (s_rd[c]) rd_n++;
        end
        check({tag, "/wr_count"}, k, nwr);
        check({tag, "/rd_count"}, rd_n, nrd);
        check({tag, "/clr_with_wr"}, clr_bad, 0);
        check({tag, "/busy_window"}, busy_bad, 0);
        check({tag, "/done_count"}, done_n, exp_done ? 1 : 0);
        if (exp_done) check({tag, "/done_cycle"}, done_c, 3 * N + 1);
        for (int i = 0; i < N; i++) begin
            check({tag, "/mem_w"}, 32'(wmem[i]), 32'((i < nwr) ? e_data[i] : w0[i]));
            check({tag, "/mem_g"}, 32'(gmem[i]), 32'((i < nwr) ? '0 : g0[i]));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            gmem[i] = W'($urandom);
            wmem[i] = W'($urandom);
        end
    endtask

    function automatic logic [W-1:0] rand_lr();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    logic [W-1:0] lr_a;

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.lr        = '0;
        bus.rd_grad   = '0;
        bus.rd_weight = '0;
        repeat (3) @(negedge clk);
        check("rst/rd_en", 32'(bus.rd_en), 0);
        check("rst/wr_en", 32'(bus.wr_en), 0);
        check("rst/grad_clr", 32'(bus.grad_clr), 0);
        check("rst/busy", 32'(bus.busy), 0);
        check("rst/done", 32'(bus.done), 0);
        check("rst/addr", 32'(bus.addr), 0);
        check("rst/wr_weight", 32'(bus.wr_weight), 0);
        rst = 1'b0;

        // Basic pass: 0x0100 - 0.5*2.0 = 0 everywhere.
        for (int i = 0; i < N; i++) begin
            gmem[i] = 16'h0200;
            wmem[i] = 16'h0100;
        end
        run_pass(16'h0080, NEVER, NEVER, NEVER, '0);
        check_pass("basic", 16'h0080, NEVER, 1'b1);
        check("basic/w0_const", 32'(wmem[0]), 32'h0000);
        check("basic/w3_const", 32'(wmem[3]), 32'h0000);
        check("basic/addr_first", s_addr[1], 0);

        // Rounding: +0.5 lsb rounds up, -0.5 lsb rounds to zero.
        fill_random();
        gmem[0] = 16'h0080; wmem[0] = 16'h0005;
        gmem[1] = 16'hFF80; wmem[1] = 16'h0005;
        run_pass(16'h0001, NEVER, NEVER, NEVER, '0);
        check_pass("round", 16'h0001, NEVER, 1'b1);
        check("round/up_const", 32'(wmem[0]), 32'h0004);
        check("round/zero_const", 32'(wmem[1]), 32'h0005);

        // Saturation at both ends.
        fill_random();
        gmem[0] = 16'h0100; wmem[0] = 16'h8010;
        gmem[1] = 16'hFF00; wmem[1] = 16'h7FF0;
        run_pass(16'h0100, NEVER, NEVER, NEVER, '0);
        check_pass("sat", 16'h0100, NEVER, 1'b1);
        check("sat/min_const", 32'(wmem[0]), 32'h8000);
        check("sat/max_const", 32'(wmem[1]), 32'h7FFF);

        // Abort in WRITE of index 1, then a fresh pass with a new lr.
        fill_random();
        lr_a = rand_lr();
        run_pass(lr_a, 6, NEVER, NEVER, '0);
        check_pass("abort", lr_a, 6, 1'b0);
        check("abort/busy_after", 32'(s_busy[7]), 0);
        fill_random();
        lr_a = rand_lr() ^ 16'h0100;
        run_pass(lr_a, NEVER, NEVER, NEVER, '0);
        check_pass("after_abort", lr_a, NEVER, 1'b1);
        check("after_abort/addr_first", s_addr[1], 0);

        // start while busy with another lr is ignored.
        fill_random();
        lr_a = rand_lr();
        run_pass(lr_a, NEVER, NEVER, 5, ~lr_a);
        check_pass("start_busy", lr_a, NEVER, 1'b1);

        // start coinciding with DONE is ignored.
        fill_random();
        lr_a = rand_lr();
        run_pass(lr_a, NEVER, NEVER, 3 * N + 1, ~lr_a);
        check_pass("start_done", lr_a, NEVER, 1'b1);

        // Reset during CALC of index 2.
        fill_random();
        lr_a = rand_lr();
        run_pass(lr_a, NEVER, 8, NEVER, '0);
        check_pass("rst_mid", lr_a, 8, 1'b0);
        check("rst_mid/wr_weight", 32'(s_wdata[9]), 0);
        check("rst_mid/addr", s_addr[9], 0);
        check("rst_mid/rd_en", 32'(s_rd[9]), 0);

        // Randomized passes, half with unrestricted learning rates.
        for (int t = 0; t < 6; t++) begin
            fill_random();
            lr_a = (t % 2 == 0) ? rand_lr() : W'($urandom);
            run_pass(lr_a, NEVER, NEVER, NEVER, '0);
            check_pass("random", lr_a, NEVER, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
